// File: rtl/lsu_mem_stage.sv
// LSU memory stage: captures one load/store from EX, runs the data-memory req/gnt/rvalid
// handshake, stalls the pipeline while the access is open and emits a one-cycle writeback.
module lsu_mem_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_is_load,
   input  logic        ex_is_store,
   input  logic [1:0]  ex_size,
   input  logic        ex_unsigned,
   input  logic [4:0]  ex_rd,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_store_data,
   input  logic        flush,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        lsu_stall,
   output logic        lsu_err,
   output logic [4:0]  lsu_wb_rd,
   output logic [31:0] lsu_wb_data,
   output logic        lsu_wb_nop,
   output logic        lsu_wb_is_load,
   output logic [1:0]  dbg_state
);

   // Handshake: the request is held (req/addr/be/we/wdata unchanged) until the cycle mem_gnt
   // is sampled high; a granted load then waits for exactly one mem_rvalid pulse.
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DRAIN} state_t;

   localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_is_load;
   logic [1:0]    r_size;
   logic          r_unsigned;
   logic [4:0]    r_rd;
   logic [1:0]    r_lane;
   logic          r_mem_req;
   logic          r_mem_we;
   logic [31:0]   r_mem_addr;
   logic [3:0]    r_mem_be;
   logic [31:0]   r_mem_wdata;
   logic          r_err;
   logic          r_wb_nop;
   logic [4:0]    r_wb_rd;
   logic [31:0]   r_wb_data;
   logic          r_wb_is_load;

   logic          w_is_mem;
   logic          w_illegal;
   logic          w_timeout;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata;
   logic [7:0]    w_ld_byte;
   logic [15:0]   w_ld_half;
   logic [31:0]   w_ld_data;

   assign w_is_mem  = ex_is_load | ex_is_store;
   assign w_illegal = (ex_size == 2'b11) ||
                      ((ex_size == 2'b01) && ex_addr[0]) ||
                      ((ex_size == 2'b10) && (ex_addr[1:0] != 2'b00));
   assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = ex_store_data;
      case (ex_size)
         2'b00: begin
            w_be    = 4'b0001 << ex_addr[1:0];
            w_wdata = {4{ex_store_data[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << ex_addr[1:0];
            w_wdata = {2{ex_store_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Lane selection uses the address captured at issue, not the live EX address.
   assign w_ld_byte = mem_rdata[{r_lane, 3'b000} +: 8];
   assign w_ld_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      w_ld_data = mem_rdata;
      case (r_size)
         2'b00:   w_ld_data = {{24{w_ld_byte[7] & ~r_unsigned}}, w_ld_byte};
         2'b01:   w_ld_data = {{16{w_ld_half[15] & ~r_unsigned}}, w_ld_half};
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_is_load    <= 1'b0;
         r_size       <= 2'b00;
         r_unsigned   <= 1'b0;
         r_rd         <= 5'd0;
         r_lane       <= 2'b00;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= 32'd0;
         r_mem_be     <= 4'd0;
         r_mem_wdata  <= 32'd0;
         r_err        <= 1'b0;
         r_wb_nop     <= 1'b1;
         r_wb_rd      <= 5'd0;
         r_wb_data    <= 32'd0;
         r_wb_is_load <= 1'b0;
      end else begin
         r_err        <= 1'b0;
         r_wb_nop     <= 1'b1;
         r_wb_rd      <= 5'd0;
         r_wb_data    <= 32'd0;
         r_wb_is_load <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (ex_valid && w_is_mem && !flush) begin
                  if (w_illegal) begin
                     r_err <= 1'b1;
                  end else begin
                     r_state     <= S_REQ;
                     r_cnt       <= '0;
                     r_is_load   <= ex_is_load;
                     r_size      <= ex_size;
                     r_unsigned  <= ex_unsigned;
                     r_rd        <= ex_rd;
                     r_lane      <= ex_addr[1:0];
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= ex_is_store;
                     r_mem_addr  <= {ex_addr[31:2], 2'b00};
                     r_mem_be    <= w_be;
                     r_mem_wdata <= w_wdata;
                  end
               end
            end
            S_REQ: begin
               if (mem_gnt || flush || w_timeout) begin
                  r_mem_req   <= 1'b0;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= 32'd0;
                  r_mem_be    <= 4'd0;
                  r_mem_wdata <= 32'd0;
               end
               // A grant wins over a same-cycle flush: the access has left the stage.
               if (mem_gnt) begin
                  r_cnt <= '0;
                  if (r_is_load) begin
                     r_state <= flush ? S_DRAIN : S_RESP;
                  end else begin
                     r_state  <= S_IDLE;
                     r_wb_nop <= flush;
                  end
               end else if (flush) begin
                  r_state <= S_IDLE;
               end else if (w_timeout) begin
                  r_state <= S_IDLE;
                  r_err   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_RESP: begin
               if (mem_rvalid) begin
                  r_state <= S_IDLE;
                  if (!flush && (r_rd != 5'd0)) begin
                     r_wb_nop     <= 1'b0;
                     r_wb_rd      <= r_rd;
                     r_wb_data    <= w_ld_data;
                     r_wb_is_load <= 1'b1;
                  end
               end else if (flush) begin
                  r_state <= S_DRAIN;
                  r_cnt   <= '0;
               end else if (w_timeout) begin
                  r_state <= S_IDLE;
                  r_err   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_DRAIN: begin
               if (mem_rvalid) begin
                  r_state <= S_IDLE;
               end else if (w_timeout) begin
                  r_state <= S_IDLE;
                  r_err   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mem_req        = r_mem_req;
   assign mem_we         = r_mem_we;
   assign mem_addr       = r_mem_addr;
   assign mem_be         = r_mem_be;
   assign mem_wdata      = r_mem_wdata;
   assign lsu_stall      = (r_state != S_IDLE);
   assign lsu_err        = r_err;
   assign lsu_wb_rd      = r_wb_rd;
   assign lsu_wb_data    = r_wb_data;
   assign lsu_wb_nop     = r_wb_nop;
   assign lsu_wb_is_load = r_wb_is_load;
   assign dbg_state      = r_state;

endmodule
